timebase_ctrl: RTL and testbench

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

---
 rtl/timebase_pkg.sv | 23 ++
 rtl/timebase_ctrl_tick_counter.sv | 35 +++
 rtl/timebase_ctrl.sv | 102 ++++++++++
 tb/tb_timebase_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared encodings and defaults for the timebase controller and its divider.
package timebase_pkg;

  localparam int DIV_W         = 9;
  localparam int SEC_W         = 7;
  localparam int DIV_DEFAULT_P = 10;
  localparam int SEC_COUNT_P   = 100;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_PAUSE = 2'b01,
    OP_STEP  = 2'b10,
    OP_LOAD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_STEP  = 2'b11
  } state_e;

endpackage

// File: rtl/timebase_ctrl_tick_counter.sv
// Period divider: counts 1..period_i while enabled and flags the terminal count.
module tick_counter
  import timebase_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // A restart wins over a coincident terminal count, so that wrap is suppressed.
  always_comb begin
    wrap_o = enable_i && !restart_i && (cnt_q == period_i);
    cnt_d  = cnt_q;
    if (restart_i || wrap_o) begin
      cnt_d = DIV_W'(1);
    end else if (enable_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= DIV_W'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Timebase controller: run/pause/step/load FSM producing 100 Hz and 1 Hz enable pulses.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int DIV_DEFAULT = DIV_DEFAULT_P,
  parameter int SEC_COUNT   = SEC_COUNT_P
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_div,
  output logic             tick_100hz,
  output logic             tick_1hz,
  output logic [1:0]       state,
  output logic             cfg_err
);

  state_e           state_q;
  logic             cmd_ready_q;
  logic             tick_100hz_q;
  logic             tick_1hz_q;
  logic             cfg_err_q;
  logic [DIV_W-1:0] div_reg_q;
  logic [SEC_W-1:0] sec_cnt_q;
  logic [SEC_W-1:0] sec_cnt_d;

  cmd_op_e op;
  logic    cmd_accept;
  logic    step_go;
  logic    load_ok;
  logic    load_bad;
  logic    wrap;
  logic    advance;
  logic    sec_wrap;

  tick_counter u_tick_counter (
    .clk_i     (clk_in),
    .rst_i     (rst),
    .enable_i  (state_q == ST_RUN),
    .restart_i (load_ok || step_go),
    .period_i  (div_reg_q),
    .wrap_o    (wrap)
  );

  // A step behaves like one forced divider wrap.
  always_comb begin
    op         = cmd_op_e'(cmd_op);
    cmd_accept = cmd_valid && cmd_ready_q;
    step_go    = cmd_accept && (op == OP_STEP);
    load_ok    = cmd_accept && (op == OP_LOAD) && (cmd_div != '0);
    load_bad   = cmd_accept && (op == OP_LOAD) && (cmd_div == '0);
    advance    = wrap || step_go;
    sec_wrap   = (sec_cnt_q == SEC_W'(SEC_COUNT - 1));
    sec_cnt_d  = sec_cnt_q;
    if (advance) begin
      sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + SEC_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      tick_100hz_q <= 1'b0;
      tick_1hz_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      div_reg_q    <= DIV_W'(DIV_DEFAULT);
      sec_cnt_q    <= '0;
    end else begin
      tick_100hz_q <= advance;
      tick_1hz_q   <= advance && sec_wrap;
      cfg_err_q    <= load_bad;
      sec_cnt_q    <= sec_cnt_d;
      cmd_ready_q  <= 1'b1;
      if (load_ok) begin
        div_reg_q <= cmd_div;
      end
      if (state_q == ST_STEP) begin
        state_q <= ST_PAUSE;
      end else if (cmd_accept) begin
        case (op)
          OP_RUN:   state_q <= ST_RUN;
          OP_PAUSE: state_q <= ST_PAUSE;
          OP_STEP: begin
            state_q     <= ST_STEP;
            cmd_ready_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign tick_100hz = tick_100hz_q;
  assign tick_1hz   = tick_1hz_q;
  assign cfg_err    = cfg_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Scoreboard bench for timebase_ctrl: expected pulse events are queued by edge number.
module tb_timebase_ctrl;
  import timebase_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [8:0] cmd_div;
  logic       tick_100hz;
  logic       tick_1hz;
  logic [1:0] state;
  logic       cfg_err;

  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    int cyc;
    bit t100;
    bit t1;
    bit err;
  } exp_t;

  exp_t expQ[$];

  timebase_ctrl #(.DIV_DEFAULT(10), .SEC_COUNT(100)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_div    (cmd_div),
    .tick_100hz (tick_100hz),
    .tick_1hz   (tick_1hz),
    .state      (state),
    .cfg_err    (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  // Edge index: value seen at a negedge is the number of the rising edge just passed.
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every pulse on an output must match the head of the expectation queue.
  always @(negedge clk_in) begin
    exp_t e;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL missing_event: expected pulse at edge %0d, not observed by edge %0d", expQ[0].cyc, cyc);
      void'(expQ.pop_front());
    end
    if (tick_100hz || tick_1hz || cfg_err) begin
      nCompared++;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        if ({tick_100hz, tick_1hz, cfg_err} !== {e.t100, e.t1, e.err}) begin
          nMismatched++;
          $display("[TB] FAIL event_bits at edge %0d: got t100/t1/err=%b%b%b, required %b%b%b",
                   cyc, tick_100hz, tick_1hz, cfg_err, e.t100, e.t1, e.err);
        end
      end else begin
        nMismatched++;
        $display("[TB] FAIL unexpected_event at edge %0d: got t100/t1/err=%b%b%b, required none",
                 cyc, tick_100hz, tick_1hz, cfg_err);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void pushExp(int c, bit t100, bit t1, bit err);
    exp_t e;
    e.cyc  = c;
    e.t100 = t100;
    e.t1   = t1;
    e.err  = err;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Present a command so that it is sampled on rising edge number 'edgeNum'.
  task automatic applyStimulus(int edgeNum, logic [1:0] op, logic [8:0] div);
    while (cyc < edgeNum - 1) @(negedge clk_in);
    checkOutput("schedule", cyc, edgeNum - 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_div   = div;
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  task automatic waitEdge(int edgeNum);
    while (cyc < edgeNum) @(negedge clk_in);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_state"}, state, ST_IDLE);
    checkOutput({tag, "_ready"}, cmd_ready, 1);
    checkOutput({tag, "_t100"}, tick_100hz, 0);
    checkOutput({tag, "_t1"}, tick_1hz, 0);
    checkOutput({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    checkResetOutputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    int e0;
    int r;
    int b;
    int l;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_div   = 9'd0;

    applyReset();

    // Default divide: ticks every 10 edges, 1 Hz tick on the 100th.
    e0 = cyc + 1;
    for (int k = 1; k <= 100; k++) pushExp(e0 + 10 * k, 1'b1, (k == 100), 1'b0);
    applyStimulus(e0, OP_RUN, 9'd0);
    checkOutput("run_state", state, ST_RUN);
    waitEdge(e0 + 1003);
    applyReset();

    // Pause holds the divider; resume finishes the remaining 5 counts.
    e0 = cyc + 1;
    pushExp(e0 + 10, 1'b1, 1'b0, 1'b0);
    pushExp(e0 + 20, 1'b1, 1'b0, 1'b0);
    applyStimulus(e0, OP_RUN, 9'd0);
    applyStimulus(e0 + 25, OP_PAUSE, 9'd0);
    checkOutput("pause_state", state, ST_PAUSE);
    r = e0 + 75;
    pushExp(r + 5, 1'b1, 1'b0, 1'b0);
    pushExp(r + 15, 1'b1, 1'b0, 1'b0);
    applyStimulus(r, OP_RUN, 9'd0);
    waitEdge(r + 17);
    applyReset();

    // Period 1 ticks every cycle; 99 ticks leave sec_cnt at 99, then STEP wraps it.
    b = cyc;
    applyStimulus(b + 1, OP_LOAD, 9'd1);
    e0 = b + 2;
    for (int k = 1; k <= 99; k++) pushExp(e0 + k, 1'b1, 1'b0, 1'b0);
    applyStimulus(e0, OP_RUN, 9'd0);
    applyStimulus(e0 + 99, OP_PAUSE, 9'd0);
    checkOutput("pre_step_state", state, ST_PAUSE);
    pushExp(e0 + 101, 1'b1, 1'b1, 1'b0);
    applyStimulus(e0 + 101, OP_STEP, 9'd0);
    checkOutput("step_state", state, ST_STEP);
    checkOutput("step_ready", cmd_ready, 0);
    @(negedge clk_in);
    checkOutput("post_step_state", state, ST_PAUSE);
    checkOutput("post_step_ready", cmd_ready, 1);
    waitEdge(e0 + 105);
    applyReset();

    // Illegal LOAD, LOAD 1, LOAD on a wrap edge, then reset during STEP.
    b = cyc;
    pushExp(b + 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(b + 1, OP_LOAD, 9'd0);
    e0 = b + 3;
    pushExp(e0 + 10, 1'b1, 1'b0, 1'b0);
    pushExp(e0 + 20, 1'b1, 1'b0, 1'b0);
    applyStimulus(e0, OP_RUN, 9'd0);
    l = e0 + 23;
    for (int k = 1; k <= 7; k++) pushExp(l + k, 1'b1, 1'b0, 1'b0);
    applyStimulus(l, OP_LOAD, 9'd1);
    pushExp(l + 18, 1'b1, 1'b0, 1'b0);
    pushExp(l + 28, 1'b1, 1'b0, 1'b0);
    applyStimulus(l + 8, OP_LOAD, 9'd10);
    pushExp(l + 45, 1'b1, 1'b0, 1'b0);
    pushExp(l + 52, 1'b1, 1'b0, 1'b0);
    applyStimulus(l + 38, OP_LOAD, 9'd7);
    pushExp(l + 55, 1'b1, 1'b0, 1'b0);
    applyStimulus(l + 55, OP_STEP, 9'd0);
    checkOutput("step2_state", state, ST_STEP);
    rst = 1'b1;
    @(negedge clk_in);
    checkResetOutputs("rst_in_step");
    rst = 1'b0;

    // Reset lands on the edge where a tick would have been produced.
    e0 = cyc + 1;
    applyStimulus(e0, OP_RUN, 9'd0);
    waitEdge(e0 + 9);
    rst = 1'b1;
    @(negedge clk_in);
    checkResetOutputs("rst_pending");
    rst = 1'b0;
    repeat (30) @(negedge clk_in);
    checkOutput("idle_state", state, ST_IDLE);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
